// File: rtl/fsgnj_pipe.sv
// Pipelined FP sign-injection unit (FSGNJ/FSGNJN/FSGNJX) with NaN-boxed single
// support at FLEN=64, elastic valid/ready stages and a tag carried per operation.
module fsgnj_pipe #(
  parameter int FLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLEN-1:0]  rs1,
  input  logic [FLEN-1:0]  rs2,
  input  logic [1:0]       op_type,
  input  logic             fmt,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLEN-1:0]  rd,
  output logic             illegal,
  output logic [TAG_W-1:0] tag_out
);

  typedef enum logic [1:0] {
    OP_SGNJ  = 2'b00,
    OP_SGNJN = 2'b01,
    OP_SGNJX = 2'b10,
    OP_ILL   = 2'b11
  } op_e;

  localparam int             SW     = $clog2(FLEN);
  localparam logic [SW-1:0]  SIGN_S = SW'(31);
  localparam logic [SW-1:0]  SIGN_D = SW'(FLEN - 1);
  localparam logic [31:0]    QNAN_S = 32'h7FC0_0000;

  logic            nan_box;
  logic [SW-1:0]   sp;
  logic [FLEN-1:0] op_a, op_b, res;
  logic            res_ill;

  // NOTE: every variable written in always_comb gets a default at the top so no path can infer a latch.
  always_comb begin
    nan_box = (FLEN == 64) && !fmt;
    sp      = ((FLEN == 64) && fmt) ? SIGN_D : SIGN_S;
    op_a    = rs1;
    op_b    = rs2;
    if (nan_box && (rs1[FLEN-1:FLEN-32] != '1)) begin
      op_a       = '1;
      op_a[31:0] = QNAN_S;
    end
    if (nan_box && (rs2[FLEN-1:FLEN-32] != '1)) begin
      op_b       = '1;
      op_b[31:0] = QNAN_S;
    end
    res     = op_a;
    res_ill = 1'b0;
    case (op_e'(op_type))
      OP_SGNJ:  res[sp] = op_b[sp];
      OP_SGNJN: res[sp] = ~op_b[sp];
      OP_SGNJX: res[sp] = op_a[sp] ^ op_b[sp];
      default:  res_ill = 1'b1;
    endcase
    // A single result living in a double register is always re-boxed, even for op 11.
    if (nan_box) res[FLEN-1:FLEN-32] = '1;
  end

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES:0]   adv;
  logic [FLEN-1:0]   rd_q  [STAGES];
  logic [FLEN-1:0]   rd_d  [STAGES];
  logic              ill_q [STAGES];
  logic              ill_d [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];

  // adv[k]: stage k may load this cycle (it is empty, or its contents move on).
  always_comb begin
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) adv[k] = !vld_q[k] || adv[k+1];
    in_ready = !rst && adv[0];

    vld_d = vld_q;
    rd_d  = rd_q;
    ill_d = ill_q;
    tag_d = tag_q;
    if (adv[0]) begin
      vld_d[0] = in_valid && in_ready;
      rd_d[0]  = res;
      ill_d[0] = res_ill;
      tag_d[0] = tag_in;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        vld_d[k] = vld_q[k-1];
        rd_d[k]  = rd_q[k-1];
        ill_d[k] = ill_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  // NOTE: payload registers carry no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    ill_q <= ill_d;
    tag_q <= tag_d;
  end

  assign out_valid = vld_q[STAGES-1];
  assign rd        = out_valid ? rd_q[STAGES-1]  : '0;
  assign illegal   = out_valid ? ill_q[STAGES-1] : 1'b0;
  assign tag_out   = out_valid ? tag_q[STAGES-1] : '0;

endmodule

// File: tb/tb_fsgnj_pipe.sv
// Self-checking bench for fsgnj_pipe: three configurations exercised with directed
// steps and random traffic against a sign/magnitude reference model.
module tb_fsgnj_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared 32-bit stimulus for instances A (STAGES=1) and B (STAGES=2)
  logic [31:0] d_rs1, d_rs2;
  logic [1:0]  d_op;
  logic [3:0]  d_tag;
  logic        d_fmt;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ill;
  logic [31:0] a_rd;
  logic [3:0]  a_tag_out;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ill;
  logic [31:0] b_rd;
  logic [3:0]  b_tag_out;

  logic [63:0] c_rs1, c_rs2, c_rd;
  logic [1:0]  c_op;
  logic        c_fmt, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ill;
  logic [3:0]  c_tag, c_tag_out;

  fsgnj_pipe #(.FLEN(32), .STAGES(1), .TAG_W(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rs1(d_rs1), .rs2(d_rs2), .op_type(d_op), .fmt(d_fmt), .tag_in(d_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .rd(a_rd),
    .illegal(a_ill), .tag_out(a_tag_out));

  fsgnj_pipe #(.FLEN(32), .STAGES(2), .TAG_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rs1(d_rs1), .rs2(d_rs2), .op_type(d_op), .fmt(d_fmt), .tag_in(d_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .rd(b_rd),
    .illegal(b_ill), .tag_out(b_tag_out));

  fsgnj_pipe #(.FLEN(64), .STAGES(3), .TAG_W(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .rs1(c_rs1), .rs2(c_rs2), .op_type(c_op), .fmt(c_fmt), .tag_in(c_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .rd(c_rd),
    .illegal(c_ill), .tag_out(c_tag_out));

  typedef struct {
    logic [64:0] r;   // {illegal, rd}
    logic [3:0]  t;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: split the selected format into sign bit and magnitude, rebuild.
  function automatic logic [64:0] model(input int flen, input logic [63:0] x,
                                        input logic [63:0] y, input logic [1:0] op,
                                        input logic fmt);
    logic [63:0] a, b, top, r;
    logic        sa, sb, ns, boxed;
    int          w;
    a     = x;
    b     = y;
    boxed = (flen == 64) && !fmt;
    w     = ((flen == 64) && fmt) ? 64 : 32;
    if (flen == 32) begin
      a = a & 64'h0000_0000_FFFF_FFFF;
      b = b & 64'h0000_0000_FFFF_FFFF;
    end
    if (boxed && (a >> 32) != 64'hFFFF_FFFF) a = 64'h7FC0_0000;
    if (boxed && (b >> 32) != 64'hFFFF_FFFF) b = 64'h7FC0_0000;
    top = 64'd1 << (w - 1);
    sa  = (a & top) != 0;
    sb  = (b & top) != 0;
    case (op)
      2'd0:    ns = sb;
      2'd1:    ns = !sb;
      2'd2:    ns = sa ^ sb;
      default: ns = sa;
    endcase
    r = (a & ~top) | (ns ? top : 64'd0);
    if (boxed) r = r | 64'hFFFF_FFFF_0000_0000;
    return {op == 2'd3, r};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] basic_exp [4];
    logic [31:0] neg_exp   [3];
    logic [64:0] m;
    exp_t        e;
    int          got, first, last;
    logic        stale;

    basic_exp = '{32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000};
    neg_exp   = '{32'hFF80_0900, 32'h7F80_0900, 32'h7F80_0900};

    d_rs1 = '0; d_rs2 = '0; d_op = '0; d_tag = '0; d_fmt = 1'b0;
    a_in_valid = 0; a_out_ready = 0; b_in_valid = 0; b_out_ready = 0;
    c_rs1 = '0; c_rs2 = '0; c_op = '0; c_fmt = 0; c_tag = '0;
    c_in_valid = 0; c_out_ready = 0;

    // Reset state
    tick();
    check("rst_in_ready_a", a_in_ready, 0);
    check("rst_in_ready_c", c_in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready_a", a_in_ready, 1);
    check("post_rst_in_ready_b", b_in_ready, 1);
    check("post_rst_in_ready_c", c_in_ready, 1);
    check("post_rst_out_valid_c", c_out_valid, 0);
    check("post_rst_rd_c", c_rd, 0);
    check("post_rst_ill_c", c_ill, 0);
    check("post_rst_tag_c", c_tag_out, 0);

    // Basic ops on A, back to back, one-cycle latency
    a_out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      d_rs1 = 32'h3F80_0000; d_rs2 = 32'hBF80_0000;
      d_op = 2'(op); d_tag = 4'(op + 1); a_in_valid = 1'b1;
      #1;
      check("basic_in_ready", a_in_ready, 1);
      tick();
      check("basic_out_valid", a_out_valid, 1);
      check("basic_rd", a_rd, basic_exp[op]);
      check("basic_ill", a_ill, op == 3);
      check("basic_tag", a_tag_out, op + 1);
    end
    for (int op = 0; op < 3; op++) begin
      d_rs1 = 32'hFF80_0900; d_rs2 = 32'hF280_2110;
      d_op = 2'(op); d_tag = 4'(op + 9);
      tick();
      check("neg_rd", a_rd, neg_exp[op]);
      check("neg_tag", a_tag_out, op + 9);
      check("neg_ill", a_ill, 0);
    end
    a_in_valid = 1'b0;
    tick();
    check("a_idle_valid", a_out_valid, 0);
    check("a_idle_rd", a_rd, 0);

    // Backpressure on B (STAGES=2)
    b_out_ready = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      d_rs1 = $urandom; d_rs2 = $urandom; d_op = 2'($urandom_range(0, 3));
      d_tag = 4'(t); b_in_valid = 1'b1;
      #1;
      check("bp_in_ready_accept", b_in_ready, 1);
      e.r = model(32, {32'b0, d_rs1}, {32'b0, d_rs2}, d_op, 1'b0);
      e.t = d_tag;
      exp_q.push_back(e);
      tick();
    end
    d_rs1 = $urandom; d_rs2 = $urandom; d_op = 2'($urandom_range(0, 3)); d_tag = 4'd3;
    #1;
    check("bp_in_ready_full", b_in_ready, 0);
    for (int s = 0; s < 2; s++) begin
      tick();
      check("bp_stall_valid", b_out_valid, 1);
      check("bp_stall_rd", b_rd, 64'(exp_q[0].r[31:0]));
      check("bp_stall_tag", b_tag_out, exp_q[0].t);
      check("bp_stall_in_ready", b_in_ready, 0);
    end
    b_out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", b_in_ready, 1);
    e.r = model(32, {32'b0, d_rs1}, {32'b0, d_rs2}, d_op, 1'b0);
    e.t = d_tag;
    exp_q.push_back(e);
    for (int j = 0; j < 3; j++) begin
      check("bp_drain_valid", b_out_valid, 1);
      e = exp_q.pop_front();
      check("bp_drain_rd", b_rd, 64'(e.r[31:0]));
      check("bp_drain_ill", b_ill, e.r[64]);
      check("bp_drain_tag", b_tag_out, e.t);
      tick();
      if (j == 0) b_in_valid = 1'b0;
    end
    check("bp_empty", b_out_valid, 0);

    // NaN-boxing on C (FLEN=64, STAGES=3)
    c_out_ready = 1'b1;
    c_rs1 = 64'h0000_0000_3F80_0000; c_rs2 = 64'hFFFF_FFFF_BF80_0000;
    c_op = 2'd0; c_fmt = 1'b0; c_tag = 4'd5; c_in_valid = 1'b1;
    tick();
    c_fmt = 1'b1; c_tag = 4'd6;
    tick();
    c_in_valid = 1'b0;
    check("box_not_yet", c_out_valid, 0);
    tick();
    check("box_single_valid", c_out_valid, 1);
    check("box_single_rd", c_rd, 64'hFFFF_FFFF_FFC0_0000);
    check("box_single_tag", c_tag_out, 5);
    tick();
    check("box_double_rd", c_rd, 64'h8000_0000_3F80_0000);
    check("box_double_tag", c_tag_out, 6);
    tick();
    check("box_empty", c_out_valid, 0);

    // Full-rate random streaming on C
    got = 0; first = -1; last = -1;
    for (int cyc = 0, issued = 0; cyc < 40 && got < 16; cyc++) begin
      if (issued < 16) begin
        c_rs1 = {$urandom, $urandom}; c_rs2 = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) c_rs1[63:32] = '1;
        if ($urandom_range(0, 1) == 1) c_rs2[63:32] = '1;
        c_op = 2'($urandom_range(0, 3)); c_fmt = 1'($urandom_range(0, 1));
        c_tag = 4'(issued); c_in_valid = 1'b1;
        check("stream_in_ready", c_in_ready, 1);
        e.r = model(64, c_rs1, c_rs2, c_op, c_fmt);
        e.t = c_tag;
        exp_q.push_back(e);
        issued++;
      end else begin
        c_in_valid = 1'b0;
      end
      tick();
      if (c_out_valid) begin
        check("stream_have_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("stream_rd", c_rd, e.r[63:0]);
          check("stream_ill", c_ill, e.r[64]);
          check("stream_tag", c_tag_out, e.t);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    c_in_valid = 1'b0;
    check("stream_count", got, 16);
    check("stream_latency", first + 1, 3);
    check("stream_consecutive", last - first, 15);

    // Reset with two ops in flight
    tick();
    for (int t = 0; t < 2; t++) begin
      c_rs1 = {$urandom, $urandom}; c_rs2 = {$urandom, $urandom};
      c_op = 2'($urandom_range(0, 3)); c_fmt = 1'b1; c_tag = 4'(12 + t);
      c_in_valid = 1'b1;
      tick();
    end
    c_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_in_ready_low", c_in_ready, 0);
    tick();
    rst = 1'b0;
    check("midrst_out_valid", c_out_valid, 0);
    check("midrst_rd", c_rd, 0);
    check("midrst_ill", c_ill, 0);
    check("midrst_tag", c_tag_out, 0);
    #1;
    check("midrst_in_ready_back", c_in_ready, 1);
    stale = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      if (c_out_valid) stale = 1'b1;
    end
    check("midrst_no_stale", stale, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
